control_unit_fsm: RTL and testbench

- Sequencing control unit for the 8-bit single-cycle CPU datapath.
- Consumes the datapath's 6-bit opcode and its registered zero flag.
- Drives the datapath select and write-enable signals, plus a new PC-enable.
- Adds run/idle/halt/wait sequencing, external stall, and illegal-opcode detection on top of per-cycle decode.

---
 rtl/control_unit_fsm.sv | 151 +++++++++++++++
 tb/tb_control_unit_fsm.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/control_unit_fsm.sv
// Sequencing control unit for the 8-bit single-cycle CPU: IDLE/RUN/WAIT/HALT with zero-latency decode.
// Optional retired-instruction counter compiled in with `define CONTROL_UNIT_PERF_EN.
module control_unit_fsm #(
    parameter int unsigned WAIT_CYCLES = 4,
    parameter int unsigned PERF_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              ext_stall,
    input  logic [5:0]        opcode,
    input  logic              z,
    output logic              s_inc,
    output logic              s_inm,
    output logic              we3,
    output logic              wez,
    output logic [2:0]        op_alu,
    output logic              pc_en,
    output logic              halted,
    output logic              illegal,
    output logic [PERF_W-1:0] retired
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             r_illegal;
    logic             w_set_illegal;

    // State, wait counter and sticky illegal flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_illegal  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_cnt;
            r_illegal  <= r_illegal | w_set_illegal;
        end
    end

    // Next state and combinational control decode
    always_comb begin
        w_next_state  = r_state;
        w_next_cnt    = r_wait_cnt;
        w_set_illegal = 1'b0;
        s_inc         = 1'b1;
        s_inm         = 1'b0;
        we3           = 1'b0;
        wez           = 1'b0;
        op_alu        = 3'b000;
        pc_en         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) w_next_state = S_RUN;
            end
            S_RUN: begin
                if (!ext_stall) begin
                    if (opcode[5]) begin
                        we3    = 1'b1;
                        wez    = 1'b1;
                        op_alu = opcode[4:2];
                        pc_en  = 1'b1;
                    end else if (opcode[4:2] == 3'b000) begin
                        s_inm = 1'b1;
                        we3   = 1'b1;
                        pc_en = 1'b1;
                    end else begin
                        case (opcode[4:0])
                            5'b00100: begin
                                s_inc = 1'b0;
                                pc_en = 1'b1;
                            end
                            5'b00101: begin
                                s_inc = ~z;
                                pc_en = 1'b1;
                            end
                            5'b00110: begin
                                s_inc = z;
                                pc_en = 1'b1;
                            end
                            5'b00111: begin
                                w_next_state = S_HALT;
                            end
                            5'b01000: begin
                                w_next_cnt   = WAIT_LOAD;
                                w_next_state = S_WAIT;
                            end
                            // NOP, and undefined opcodes executed as NOP
                            default: begin
                                pc_en         = 1'b1;
                                w_set_illegal = (opcode[4:0] != 5'b01001);
                            end
                        endcase
                    end
                end
            end
            S_WAIT: begin
                if (!ext_stall) begin
                    if (r_wait_cnt == '0) begin
                        pc_en        = 1'b1;
                        w_next_state = S_RUN;
                    end else begin
                        w_next_cnt = r_wait_cnt - CNT_W'(1);
                    end
                end
            end
            S_HALT: begin
                if (!ext_stall && start) begin
                    pc_en        = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign halted  = (r_state == S_HALT);
    assign illegal = r_illegal;

`ifdef CONTROL_UNIT_PERF_EN
    logic [PERF_W-1:0] r_retired;

    // Counts every cycle the PC advances, wrapping naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retired <= '0;
        end else if (pc_en) begin
            r_retired <= r_retired + PERF_W'(1);
        end
    end

    assign retired = r_retired;
`else
    assign retired = '0;
`endif

endmodule

// File: tb/tb_control_unit_fsm.sv
// Self-checking bench for control_unit_fsm: table of per-cycle vectors plus async-reset sequences.
module tb_control_unit_fsm;

    localparam int unsigned PERF_W = 16;
`ifdef CONTROL_UNIT_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              start;
    logic              ext_stall;
    logic [5:0]        opcode;
    logic              z;
    logic              s_inc;
    logic              s_inm;
    logic              we3;
    logic              wez;
    logic [2:0]        op_alu;
    logic              pc_en;
    logic              halted;
    logic              illegal;
    logic [PERF_W-1:0] retired;

    control_unit_fsm #(.WAIT_CYCLES(4), .PERF_W(PERF_W)) dut (
        .clk(clk), .reset(reset), .start(start), .ext_stall(ext_stall),
        .opcode(opcode), .z(z), .s_inc(s_inc), .s_inm(s_inm), .we3(we3),
        .wez(wez), .op_alu(op_alu), .pc_en(pc_en), .halted(halted),
        .illegal(illegal), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       stl;
        logic [5:0] op;
        logic       zz;
        logic [9:0] exp;
    } vec_t;

    typedef struct {
        logic [9:0]        ctrl;
        logic [PERF_W-1:0] ret;
        int                id;
    } sb_t;

    vec_t vecs[$];
    sb_t  sbq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   vid    = 0;
    logic [PERF_W-1:0] exp_ret = '0;

    // {s_inc, s_inm, we3, wez, op_alu, pc_en, halted, illegal}
    function automatic logic [9:0] e(input logic si, input logic sm, input logic w3,
                                     input logic wz, input logic [2:0] op, input logic pe,
                                     input logic hl, input logic il);
        return {si, sm, w3, wz, op, pe, hl, il};
    endfunction

    task automatic add(input logic st, input logic stl, input logic [5:0] op,
                       input logic zz, input logic [9:0] ex);
        vec_t v;
        v.st = st; v.stl = stl; v.op = op; v.zz = zz; v.exp = ex;
        vecs.push_back(v);
    endtask

    task automatic push_exp(input logic [9:0] ex);
        sb_t s;
        s.ctrl = ex;
        s.ret  = PERF ? exp_ret : '0;
        s.id   = vid;
        sbq.push_back(s);
        vid++;
    endtask

    task automatic pop_check();
        sb_t s;
        logic [9:0] act;
        if (sbq.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL scoreboard_empty");
            return;
        end
        s   = sbq.pop_front();
        act = {s_inc, s_inm, we3, wez, op_alu, pc_en, halted, illegal};
        n_cmp++;
        if (act !== s.ctrl) begin
            n_fail++;
            $display("FAIL ctrl_vec%0d: got %b expected %b", s.id, act, s.ctrl);
        end
        n_cmp++;
        if (retired !== s.ret) begin
            n_fail++;
            $display("FAIL retired_vec%0d: got %0d expected %0d", s.id, retired, s.ret);
        end
    endtask

    // Drive one cycle at the falling edge, check combinational outputs shortly after
    task automatic step(input logic st, input logic stl, input logic [5:0] op,
                        input logic zz, input logic [9:0] ex);
        @(negedge clk);
        start = st; ext_stall = stl; opcode = op; z = zz;
        push_exp(ex);
        #1;
        pop_check();
        if (ex[2] && reset) exp_ret = exp_ret + PERF_W'(1);
    endtask

    logic [9:0] DEF;
    logic [9:0] DEFI;
    logic [9:0] HLT;
    logic [9:0] NOPX;

    initial begin
        DEF  = e(1, 0, 0, 0, 3'b000, 0, 0, 0);
        DEFI = e(1, 0, 0, 0, 3'b000, 0, 0, 1);
        HLT  = e(1, 0, 0, 0, 3'b000, 0, 1, 0);
        NOPX = e(1, 0, 0, 0, 3'b000, 1, 0, 0);
        reset = 1'b0; start = 1'b0; ext_stall = 1'b0; opcode = 6'b000000; z = 1'b0;

        add(0, 0, 6'b100000, 0, DEF);                         // IDLE ignores opcode
        add(1, 0, 6'b101100, 0, DEF);                         // start leaves IDLE
        add(0, 0, 6'b101100, 0, e(1, 0, 1, 1, 3'b011, 1, 0, 0));
        add(0, 0, 6'b100011, 0, e(1, 0, 1, 1, 3'b000, 1, 0, 0));
        add(0, 0, 6'b111111, 0, e(1, 0, 1, 1, 3'b111, 1, 0, 0));
        add(0, 0, 6'b000010, 0, e(1, 1, 1, 0, 3'b000, 1, 0, 0));
        add(0, 0, 6'b000100, 0, e(0, 0, 0, 0, 3'b000, 1, 0, 0));
        add(0, 0, 6'b000101, 1, e(0, 0, 0, 0, 3'b000, 1, 0, 0));
        add(0, 0, 6'b000101, 0, NOPX);
        add(0, 0, 6'b000110, 1, NOPX);
        add(0, 0, 6'b000110, 0, e(0, 0, 0, 0, 3'b000, 1, 0, 0));
        add(0, 0, 6'b001001, 0, NOPX);
        add(0, 1, 6'b101100, 0, DEF);                         // stall in RUN
        add(1, 0, 6'b110000, 0, e(1, 0, 1, 1, 3'b100, 1, 0, 0));
        add(0, 0, 6'b001000, 0, DEF);                         // WAIT issue
        add(0, 0, 6'b101100, 0, DEF);
        add(0, 1, 6'b101100, 0, DEF);
        add(0, 1, 6'b101100, 0, DEF);
        add(0, 0, 6'b101100, 0, DEF);
        add(0, 0, 6'b101100, 0, DEF);
        add(0, 0, 6'b101100, 0, NOPX);                        // WAIT exit, 7th cycle
        add(0, 0, 6'b100100, 0, e(1, 0, 1, 1, 3'b001, 1, 0, 0));
        add(0, 0, 6'b000111, 0, DEF);                         // HALT issue
        add(0, 0, 6'b101100, 0, HLT);
        add(0, 0, 6'b101100, 0, HLT);
        add(1, 1, 6'b101100, 0, HLT);                         // stall beats start
        add(1, 0, 6'b101100, 0, e(1, 0, 0, 0, 3'b000, 1, 1, 0));
        add(0, 0, 6'b001001, 0, NOPX);
        add(0, 0, 6'b010000, 0, NOPX);                        // illegal as NOP
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 1) add(0, 0, 6'b101000, 0, e(1, 0, 1, 1, 3'b010, 1, 0, 1));
            else            add(0, 0, 6'b001001, 0, e(1, 0, 0, 0, 3'b000, 1, 0, 1));
        end

        repeat (2) @(negedge clk);
        step(0, 0, 6'b101100, 0, DEF);                        // during reset
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].st, vecs[i].stl, vecs[i].op, vecs[i].zz, vecs[i].exp);
        end

        // Async reset in the middle of WAIT
        step(0, 0, 6'b001000, 0, DEFI);
        step(0, 0, 6'b101100, 0, DEFI);
        #2 reset = 1'b0;
        exp_ret = '0;
        push_exp(DEF);
        #1 pop_check();
        @(negedge clk) reset = 1'b1;
        step(0, 0, 6'b101100, 0, DEF);                        // back in IDLE
        step(1, 0, 6'b101100, 0, DEF);
        step(0, 0, 6'b011111, 0, NOPX);                       // top illegal code
        step(0, 0, 6'b001001, 0, e(1, 0, 0, 0, 3'b000, 1, 0, 1));
        step(0, 0, 6'b000111, 0, DEFI);
        step(0, 0, 6'b101100, 0, e(1, 0, 0, 0, 3'b000, 0, 1, 1));
        // Async reset in the middle of HALT
        #2 reset = 1'b0;
        exp_ret = '0;
        push_exp(DEF);
        #1 pop_check();
        @(negedge clk) reset = 1'b1;
        step(1, 0, 6'b001010, 0, DEF);
        step(0, 0, 6'b001010, 0, NOPX);                       // lowest illegal code
        step(0, 0, 6'b000100, 0, e(0, 0, 0, 0, 3'b000, 1, 0, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
